adc_channel_sequencer: RTL and testbench

Round-robin scheduler that shares one ADC conversion core among NCH requesting channels. Arbitrates pending requests, drives the analog-mux select and ADC enable, waits out a settle interval, captures the first valid conversion and returns it to the granted channel with a one-cycle acknowledge. It sits between the digital requesters and the ADC converter model, and owns the ADC's enable and select lines.

---
 rtl/adc_channel_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_adc_channel_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer
//
// Round-robin scheduler that shares one ADC conversion core among NCH requesting
// channels. A pending request is granted in IDLE, the analog mux is settled with
// the ADC disabled, the first valid conversion after the first CONVERT cycle is
// captured, and the result is returned with a one-cycle one-hot acknowledge.
//
// Optional feature macro: ADC_SEQ_TIMEOUT_EN
//   defined   : CONVERT aborts after TIMEOUT_CYC cycles; ack pulses with err=1, result=0.
//   undefined : CONVERT waits indefinitely and err is tied low.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   req_i            per-channel conversion request (level)
//   ack_o            one-hot, one-cycle pulse: result_o is valid for that channel
//   result_o         conversion result, valid while ack_o != 0
//   err_o            one-cycle pulse with ack_o when the conversion timed out
//   busy_o           high whenever the sequencer is not idle
//   adc_sel_o        analog mux channel select
//   adc_enable_o     ADC enable (high only in CONVERT)
//   adc_data_ready_i ADC result-valid flag
//   adc_q_i          ADC result
module adc_channel_sequencer #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned NBITS       = 8,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           req_i,
    output logic [NCH-1:0]           ack_o,
    output logic [NBITS-1:0]         result_o,
    output logic                     err_o,
    output logic                     busy_o,
    output logic [$clog2(NCH)-1:0]   adc_sel_o,
    output logic                     adc_enable_o,
    input  logic                     adc_data_ready_i,
    input  logic [NBITS-1:0]         adc_q_i
);

    localparam int unsigned SelW = $clog2(NCH);
    localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StConvert, StDone} state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   grant_q, grant_d;
    logic [SelW-1:0]   ptr_q, ptr_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic              first_q, first_d;   // first CONVERT cycle: ready flag may be stale
    logic [NBITS-1:0]  result_q, result_d;

    logic              pick_vld;
    logic [SelW-1:0]   pick_idx;
    logic [SelW-1:0]   idx;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;
`else
    logic              unused_tmo_cfg;
    assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

    // Lowest requesting index at or after ptr, wrapping modulo NCH.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = SelW'((32'(ptr_q) + i) % NCH);
            if (!pick_vld && req_i[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        settle_d = settle_q;
        first_d  = first_q;
        result_d = result_q;
`ifdef ADC_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d  = pick_idx;
                    settle_d = SetW'(SETTLE_CYC - 1);
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                if (settle_q == '0) begin
                    first_d = 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                    state_d = StConvert;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StConvert: begin
                first_d = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
                tmo_d   = tmo_q + TmoW'(1);
`endif
                if (!first_q && adc_data_ready_i) begin
                    result_d = adc_q_i;
`ifdef ADC_SEQ_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = StDone;
                end
`ifdef ADC_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = StDone;
                end
`endif
            end
            StDone: begin
                ptr_d   = (grant_q == SelW'(NCH - 1)) ? '0 : grant_q + SelW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            ptr_q    <= '0;
            settle_q <= '0;
            first_q  <= 1'b0;
            result_q <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            settle_q <= settle_d;
            first_q  <= first_d;
            result_q <= result_d;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        ack_o = '0;
        if (state_q == StDone) begin
            ack_o = NCH'(1) << grant_q;
        end
    end

`ifdef ADC_SEQ_TIMEOUT_EN
    assign err_o = (state_q == StDone) && err_q;
`else
    assign err_o = 1'b0;
`endif

    assign result_o     = result_q;
    assign busy_o       = (state_q != StIdle);
    assign adc_sel_o    = grant_q;
    assign adc_enable_o = (state_q == StConvert);

endmodule

// File: tb/tb_adc_channel_sequencer.sv
module tb_adc_channel_sequencer;

    localparam int NCH   = 4;
    localparam int NBITS = 8;
    localparam int S     = 2;
    localparam int TMO   = 16;
    localparam int SELW  = $clog2(NCH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   req;
    logic [NCH-1:0]   ack;
    logic [NBITS-1:0] result;
    logic             err;
    logic             busy;
    logic [SELW-1:0]  adc_sel;
    logic             adc_enable;
    logic             adc_data_ready;
    logic [NBITS-1:0] adc_q;

    adc_channel_sequencer #(
        .NCH         (NCH),
        .NBITS       (NBITS),
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req),
        .ack_o            (ack),
        .result_o         (result),
        .err_o            (err),
        .busy_o           (busy),
        .adc_sel_o        (adc_sel),
        .adc_enable_o     (adc_enable),
        .adc_data_ready_i (adc_data_ready),
        .adc_q_i          (adc_q)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Transaction-level reference: one grant at a time, described by its
    // position m_t on the timeline (1..S settle, S+1..S+k convert, S+k+1 done).
    bit m_idle;
    int m_ptr, m_grant, m_t, m_k, m_data;
    bit m_stale, m_tmo;
    int nx_k, nx_data;
    bit nx_stale, nx_tmo;
    bit last_err;

    typedef struct {
        logic [NCH-1:0] req;
        int             k;
        int             data;
        bit             stale;
        int             exp_chan;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [NCH-1:0] r);
        for (int i = 0; i < NCH; i++) begin
            if (r[(ptr + i) % NCH]) return (ptr + i) % NCH;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        logic [NCH-1:0] e_ack;
        bit e_en, e_done;
        e_done = !m_idle && (m_t == S + m_k + 1);
        e_en   = !m_idle && (m_t > S) && (m_t <= S + m_k);
        e_ack  = e_done ? NCH'(1 << m_grant) : '0;
        chk("ack", 32'(ack), 32'(e_ack));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("adc_enable", 32'(adc_enable), 32'(e_en));
        if (!m_idle) chk("adc_sel", 32'(adc_sel), m_grant);
        if (e_done) begin
            chk("result", 32'(result), m_tmo ? 0 : m_data);
            chk("err", 32'(err), 32'(m_tmo));
        end else begin
            chk("err_quiet", 32'(err), 0);
        end
    endtask

    // Drive one cycle of inputs, advance the reference, then check after the edge.
    task automatic cycle(input logic [NCH-1:0] r);
        bit rdy, conv, hit;
        req  = r;
        conv = !m_idle && (m_t > S) && (m_t <= S + m_k);
        hit  = conv && !m_tmo && (m_t == S + m_k);
        if (conv) rdy = hit || (m_stale && m_t == S + 1);
        else      rdy = 1'($urandom_range(0, 1));
        adc_data_ready = rdy;
        adc_q = hit ? NBITS'(m_data) : NBITS'($urandom);

        if (m_idle) begin
            if (r != '0) begin
                m_grant = rr_pick(m_ptr, r);
                m_idle  = 1'b0;
                m_t     = 1;
                m_data  = nx_data;
                m_stale = nx_stale && !nx_tmo;
                m_tmo   = nx_tmo;
`ifdef ADC_SEQ_TIMEOUT_EN
                m_k     = nx_tmo ? TMO : nx_k;
`else
                m_k     = nx_tmo ? (1 << 20) : nx_k;
`endif
            end
        end else if (m_t == S + m_k + 1) begin
            m_idle = 1'b1;
            m_ptr  = (m_grant + 1) % NCH;
        end else begin
            m_t++;
        end

        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic run_until_ack(input logic [NCH-1:0] r_first, input logic [NCH-1:0] r_rest,
                                 input int bound, output int chan);
        chan = -1;
        for (int i = 0; i < bound; i++) begin
            cycle((i == 0) ? r_first : r_rest);
            if (ack != '0) begin
                chan     = onehot_idx(ack);
                last_err = err;
                break;
            end
        end
        if (chan < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_wait: no ack within %0d cycles (cycle %0d)", bound, cyc);
        end
    endtask

    task automatic reset_mid();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_enable", 32'(adc_enable), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_sel", 32'(adc_sel), 0);
        chk("rst_result", 32'(result), 0);
        m_idle = 1'b1;
        m_ptr  = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int ch;

        tbl[0]  = '{4'b0100, 2, 4,    0, 2};
        tbl[1]  = '{4'b1000, 3, 8'hA5, 1, 3};
        tbl[2]  = '{4'b1111, 2, 8'h11, 0, 0};
        tbl[3]  = '{4'b1111, 4, 8'h22, 1, 1};
        tbl[4]  = '{4'b1111, 2, 8'h33, 0, 2};
        tbl[5]  = '{4'b1111, 5, 8'h44, 1, 3};
        tbl[6]  = '{4'b1111, 3, 8'h55, 0, 0};
        tbl[7]  = '{4'b1111, 2, 8'h66, 1, 1};
        tbl[8]  = '{4'b1111, 6, 8'h77, 0, 2};
        tbl[9]  = '{4'b1111, 2, 8'hFF, 0, 3};
        tbl[10] = '{4'b0101, 2, 8'h00, 1, 0};
        tbl[11] = '{4'b0101, 3, 8'h81, 0, 2};
        tbl[12] = '{4'b0011, 2, 8'h7E, 0, 0};
        tbl[13] = '{4'b0011, 4, 8'hC3, 1, 1};

        m_idle = 1'b1; m_ptr = 0; m_grant = 0; m_t = 0; m_k = 2; m_data = 0;
        m_stale = 1'b0; m_tmo = 1'b0;
        nx_k = 2; nx_data = 0; nx_stale = 1'b0; nx_tmo = 1'b0;

        rst_n = 1'b0; req = '0; adc_data_ready = 1'b0; adc_q = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", 32'(ack), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_enable", 32'(adc_enable), 0);
        chk("reset_sel", 32'(adc_sel), 0);
        rst_n = 1'b1;

        // Directed vectors, run back to back with req held through each service.
        for (int e = 0; e < 14; e++) begin
            nx_k = tbl[e].k; nx_data = tbl[e].data; nx_stale = tbl[e].stale;
            run_until_ack(tbl[e].req, tbl[e].req, 60, ch);
            chk($sformatf("tbl%0d_chan", e), ch, tbl[e].exp_chan);
        end

        // Request withdrawn after one IDLE cycle still completes.
        cycle('0);
        nx_k = 3; nx_data = 8'h5A; nx_stale = 1'b0;
        run_until_ack(4'b0010, 4'b0000, 60, ch);
        chk("withdrawn_chan", ch, 1);

        // Reset in CONVERT with ptr=2; afterwards arbitration restarts from 0.
        cycle('0);
        nx_k = 6;
        cycle(4'b0100);
        repeat (S + 2) cycle('0);
        chk("pre_reset_enable", 32'(adc_enable), 1);
        reset_mid();
        nx_k = 2; nx_data = 8'h3C;
        run_until_ack(4'b1001, 4'b1001, 60, ch);
        chk("post_reset_chan", ch, 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            nx_k     = $urandom_range(2, 6);
            nx_data  = $urandom_range(0, 255);
            nx_stale = 1'($urandom_range(0, 1));
            cycle($urandom_range(0, 1) ? NCH'($urandom) : '0);
        end
        for (int i = 0; i < 40 && !m_idle; i++) cycle('0);

        // ADC never reports ready.
        nx_tmo = 1'b1; nx_stale = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
        run_until_ack(4'b0001, 4'b0000, 60, ch);
        chk("tmo_chan", ch, 0);
        chk("tmo_err", 32'(last_err), 1);
        nx_tmo = 1'b0;
`else
        cycle(4'b0001);
        repeat (40) cycle('0);
        chk("stuck_busy", 32'(busy), 1);
        chk("stuck_enable", 32'(adc_enable), 1);
        nx_tmo = 1'b0;
        reset_mid();
`endif
        nx_k = 2; nx_data = 8'h99;
        run_until_ack(4'b1000, 4'b0000, 60, ch);
        chk("final_chan", ch, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
